seg_scan_adder: RTL and testbench

Parametrised successor to the single-digit adder/display path. It registers the sum of two WIDTH-bit operands on a load strobe and shows it in hex on a DIGITS-digit multiplexed seven-segment display, with the carry-out on the decimal point. Digits are scanned automatically by a refresh prescaler, or a digit can be forced manually. It sits between the board switches/buttons and the seven-segment pins.

---
 rtl/seg_pkg.sv | 19 +
 rtl/hex7seg.sv | 11 +
 rtl/seg_scan_adder.sv | 125 ++++++++++++
 tb/tb_seg_scan_adder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: hex glyph table,
// blank pattern and the all-anodes-off helper.
package seg_pkg;

  localparam int MAX_DIGITS = 32;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [MAX_DIGITS-1:0] an_off();
    return {MAX_DIGITS{1'b1}};
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_adder.sv
// Registered adder driving a multiplexed hex seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (k>0).
module seg_scan_adder
  import seg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      load,
  input  logic                      auto_scan,
  input  logic [$clog2(DIGITS)-1:0] sel,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [DIGITS-1:0]         an
);

  localparam int SW = $clog2(DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int NW = DIGITS * 4;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]     SCAN_LAST  = SW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = DIGITS'(an_off());

  if (DIGITS * 4 < WIDTH) begin : g_bad_width
    $error("seg_scan_adder: DIGITS*4 must be >= WIDTH");
  end
  if (DIGITS < 2 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seg_scan_adder: DIGITS out of range");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("seg_scan_adder: REFRESH_DIV must be >= 2");
  end

  logic [WIDTH:0]      sum_r;
  logic [PW-1:0]       presc_r;
  logic [SW-1:0]       scan_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;

  logic [NW-1:0]       digits_s;
  logic [SW-1:0]       idx_s;
  logic                idx_ok_s;
  logic [3:0]          nibble_s;
  logic                blank_s;
  logic [6:0]          dec_s;

  assign digits_s = NW'(sum_r[WIDTH-1:0]);

  // Sum capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r <= '0;
    end else if (load) begin
      sum_r <= {1'b0, a} + {1'b0, b};
    end else begin
      sum_r <= sum_r;
    end
  end

  // Refresh prescaler and scan index; they keep running in manual mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= '0;
      scan_r  <= '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      scan_r  <= (scan_r == SCAN_LAST) ? '0 : scan_r + 1'b1;
    end else begin
      presc_r <= presc_r + 1'b1;
      scan_r  <= scan_r;
    end
  end

  // Active digit selection, nibble extraction and optional blanking
  always_comb begin
    idx_s    = scan_r;
    idx_ok_s = 1'b1;
    if (auto_scan) begin
      idx_s    = scan_r;
      idx_ok_s = 1'b1;
    end else begin
      idx_s    = sel;
      idx_ok_s = ({1'b0, sel} < (SW+1)'(DIGITS));
    end
    nibble_s = digits_s[4*int'(idx_s) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank_s  = (idx_s != '0) && ((digits_s >> (4*int'(idx_s))) == '0);
`else
    blank_s  = 1'b0;
`endif
  end

  hex7seg u_hex7seg (
    .hex (nibble_s),
    .seg (dec_s)
  );

  // Display output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
      an_r  <= AN_OFF;
    end else if (idx_ok_s) begin
      seg_r <= blank_s ? SEG_BLANK : dec_s;
      dp_r  <= ~((idx_s == '0) && sum_r[WIDTH]);
      an_r  <= ~(DIGITS'(1) << idx_s);
    end else begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
      an_r  <= AN_OFF;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule

// File: tb/tb_seg_scan_adder.sv
// Scoreboard bench for seg_scan_adder (WIDTH=8, DIGITS=4, REFRESH_DIV=4);
// honours LEADING_ZERO_BLANK_EN in its reference model.
module tb_seg_scan_adder;

  localparam int WIDTH = 8;
  localparam int DIGITS = 4;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       load = 1'b0;
  logic       auto_scan = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  seg_scan_adder #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .load(load),
    .auto_scan(auto_scan), .sel(sel), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q [$];

  // reference model state: sum and cycles elapsed since reset release
  int m_sum = 0;
  int m_t = 0;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [11:0] model_out(input logic r, input logic au, input int sl);
    int idx;
    int low;
    logic [6:0] s;
    logic d;
    logic [3:0] anv;
    if (!r) return {7'h7F, 1'b1, 4'hF};
    idx = au ? (m_t / DIV) % DIGITS : sl;
    low = m_sum % 256;
    s = glyph((low / (1 << (4*idx))) % 16);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (low / (1 << (4*idx))) == 0) s = 7'h7F;
`endif
    d = (idx == 0 && m_sum >= 256) ? 1'b0 : 1'b1;
    anv = 4'hF;
    anv[idx] = 1'b0;
    return {s, d, anv};
  endfunction

  task automatic step(input logic r, input logic ld, input logic [7:0] aa,
                      input logic [7:0] bb, input logic au, input logic [1:0] sl);
    @(negedge clk);
    rst_n = r; load = ld; a = aa; b = bb; auto_scan = au; sel = sl;
    exp_q.push_back(model_out(r, au, int'(sl)));
    if (!r) begin
      m_sum = 0;
      m_t = 0;
    end else begin
      if (ld) m_sum = int'(aa) + int'(bb);
      m_t = m_t + 1;
    end
  endtask

  task automatic idle(input int n, input logic au, input logic [1:0] sl);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, au, sl);
  endtask

  // monitor: one expected word per clock edge
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({seg, dp, an} !== e) begin
          bad++;
          $display("FAIL display @%0t: got seg=%b dp=%b an=%b, want seg=%b dp=%b an=%b",
                   $time, seg, dp, an, e[11:5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    // reset held 3 cycles, then auto scan
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 2'd0);
    idle(3, 1'b1, 2'd0);
    step(1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 2'd0);
    idle(20, 1'b1, 2'd0);
    // carry out on dp
    step(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 2'd0);
    idle(20, 1'b1, 2'd0);
    // manual selection then back to auto
    idle(10, 1'b0, 2'd2);
    idle(5, 1'b0, 2'd3);
    idle(9, 1'b1, 2'd3);
    // reset mid-scan with load asserted
    step(1'b1, 1'b1, 8'hA5, 8'h5A, 1'b1, 2'd0);
    step(1'b0, 1'b1, 8'h77, 8'h11, 1'b1, 2'd0);
    idle(18, 1'b1, 2'd0);
    // small value for leading-zero behaviour
    step(1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 2'd0);
    idle(18, 1'b1, 2'd0);
    step(1'b1, 1'b1, 8'h80, 8'h90, 1'b0, 2'd0);
    idle(6, 1'b0, 2'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
           8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)));
    end
    idle(2, 1'b1, 2'd0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
